// File: rtl/led_seq_pkg.sv
// Shared types and defaults for the two-LED blink sequencer.
// The key-debounce constant exists only when LED_SEQ_KEY_EN is defined.
package led_seq_pkg;

    localparam int          DEF_CNT_W       = 26;
    localparam int unsigned DEF_HALF_PERIOD = 24_999_999;
    localparam logic [1:0]  DEF_RESET_MODE  = 2'b01;
`ifdef LED_SEQ_KEY_EN
    localparam int          DEB_W            = 20;
    localparam logic [19:0] DEF_DEBOUNCE_CYC = 20'd999_999;
`endif

    typedef enum logic [1:0] {
        MODE_OFF  = 2'b00,
        MODE_SYNC = 2'b01,
        MODE_ALT  = 2'b10,
        MODE_BIN  = 2'b11
    } mode_e;

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_PEND = 1'b1
    } state_e;

    function automatic logic [1:0] led_pattern(input mode_e mode, input logic [1:0] phase);
        logic [1:0] pat;
        pat = 2'b00;
        case (mode)
            MODE_OFF:  pat = 2'b00;
            MODE_SYNC: pat = {phase[0], phase[0]};
            MODE_ALT:  pat = phase[0] ? 2'b10 : 2'b01;
            MODE_BIN:  pat = phase;
            default:   pat = 2'b00;
        endcase
        return pat;
    endfunction

    function automatic mode_e next_mode(input mode_e mode);
        mode_e nxt;
        nxt = MODE_SYNC;
        case (mode)
            MODE_OFF:  nxt = MODE_SYNC;
            MODE_SYNC: nxt = MODE_ALT;
            MODE_ALT:  nxt = MODE_BIN;
            MODE_BIN:  nxt = MODE_OFF;
            default:   nxt = MODE_SYNC;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/led_seq_ctrl_key_debounce.sv
// Push-button conditioner: 2-FF synchronizer, stability counter, one-cycle press pulse.
// Built only when LED_SEQ_KEY_EN is defined.
`ifdef LED_SEQ_KEY_EN
module key_debounce
    import led_seq_pkg::*;
#(
    parameter logic [DEB_W-1:0] DEBOUNCE_CYC = DEF_DEBOUNCE_CYC
) (
    input  logic clk,
    input  logic rst_n,
    input  logic key_n,
    output logic press
);

    logic [1:0]       sync_ff;
    logic             db;
    logic [DEB_W-1:0] cnt;

    // db only follows the synchronized key after DEBOUNCE_CYC+1 consecutive differing samples
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_ff <= 2'b11;
            db      <= 1'b1;
            cnt     <= '0;
            press   <= 1'b0;
        end else begin
            sync_ff <= {sync_ff[0], key_n};
            press   <= 1'b0;
            if (sync_ff[1] == db) begin
                cnt <= '0;
            end else if (cnt == DEBOUNCE_CYC) begin
                cnt   <= '0;
                db    <= sync_ff[1];
                press <= db;
            end else begin
                cnt <= cnt + DEB_W'(1);
            end
        end
    end

endmodule
`endif

// File: rtl/led_seq_ctrl.sv
// Two-LED blink sequencer with glitch-free mode/period updates on half-period boundaries.
// Defining LED_SEQ_KEY_EN adds a debounced push button that cycles the mode.
module led_seq_ctrl
    import led_seq_pkg::*;
#(
    parameter int               CNT_W       = DEF_CNT_W,
    parameter logic [CNT_W-1:0] HALF_PERIOD = CNT_W'(DEF_HALF_PERIOD),
    parameter logic [1:0]       RESET_MODE  = DEF_RESET_MODE
`ifdef LED_SEQ_KEY_EN
    ,
    parameter logic [DEB_W-1:0] DEBOUNCE_CYC = DEF_DEBOUNCE_CYC
`endif
) (
    input  logic             sys_clk,
    input  logic             sys_rst_n,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic [1:0]       cfg_mode,
    input  logic [CNT_W-1:0] cfg_period,
`ifdef LED_SEQ_KEY_EN
    input  logic             key_n,
`endif
    output logic [1:0]       led,
    output logic [CNT_W-1:0] count,
    output logic             tick,
    output state_e           state
);

    // Handshake: a request is taken on any edge where valid and ready are both high;
    // the requester holds mode/period stable until then, and valid without ready is ignored.

    mode_e            mode_r, pend_mode, req_mode;
    logic [CNT_W-1:0] period_r, pend_period, req_period;
    logic [1:0]       phase_r;
    logic             req_valid;
    state_e           state_nx;
    logic             apply_now, apply_pend, load_pend;

`ifdef LED_SEQ_KEY_EN
    logic key_press;

    key_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_key (
        .clk   (sys_clk),
        .rst_n (sys_rst_n),
        .key_n (key_n),
        .press (key_press)
    );

    // The cfg port has priority; a simultaneous key press is simply lost
    always_comb begin
        req_valid  = cfg_valid | key_press;
        req_mode   = cfg_valid ? mode_e'(cfg_mode) : next_mode(mode_r);
        req_period = cfg_valid ? cfg_period : period_r;
    end
`else
    always_comb begin
        req_valid  = cfg_valid;
        req_mode   = mode_e'(cfg_mode);
        req_period = cfg_period;
    end
`endif

    assign tick = (count == period_r);

    always_comb begin
        state_nx   = state;
        cfg_ready  = (state == ST_RUN);
        apply_now  = 1'b0;
        apply_pend = 1'b0;
        load_pend  = 1'b0;
        case (state)
            ST_RUN: begin
                if (req_valid) begin
                    if (mode_r == MODE_OFF) begin
                        apply_now = 1'b1;
                    end else begin
                        load_pend = 1'b1;
                        state_nx  = ST_PEND;
                    end
                end
            end
            ST_PEND: begin
                if (tick) begin
                    apply_pend = 1'b1;
                    state_nx   = ST_RUN;
                end
            end
            default: state_nx = ST_RUN;
        endcase
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) state <= ST_RUN;
        else            state <= state_nx;
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            mode_r      <= mode_e'(RESET_MODE);
            period_r    <= HALF_PERIOD;
            pend_mode   <= mode_e'(RESET_MODE);
            pend_period <= HALF_PERIOD;
            count       <= '0;
            phase_r     <= 2'd0;
            led         <= 2'b00;
        end else begin
            led <= led_pattern(mode_r, phase_r);
            if (load_pend) begin
                pend_mode   <= req_mode;
                pend_period <= req_period;
            end
            if (apply_now) begin
                mode_r   <= req_mode;
                period_r <= req_period;
            end else if (apply_pend) begin
                mode_r   <= pend_mode;
                period_r <= pend_period;
            end
            // A new setting restarts the pattern at phase 0 with a fresh half-period
            if (apply_now || apply_pend) begin
                count   <= '0;
                phase_r <= 2'd0;
            end else if (tick) begin
                count   <= '0;
                phase_r <= phase_r + 2'd1;
            end else begin
                count <= count + CNT_W'(1);
            end
        end
    end

endmodule
